// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encodings and
// the default pattern width.
package sequence_generator_pkg;

    // Only three legal states; the fourth encoding is treated as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_LEN = 8;

endpackage : sequence_generator_pkg

// File: rtl/sequence_generator.sv
// Serial pattern transmitter. A pattern, its length and a repeat count are
// accepted through start/ready, then shifted out MSB-first (bit len-1 first)
// one bit per clock, with optional idle gaps between passes. All outputs are
// registered: the next-state logic decides what the line carries next cycle
// and the output decode turns that decision into the registered values.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   repeat_cnt,
    input  logic               abort,
    output logic               ready,
    output logic               out,
    output logic               out_valid,
    output logic               done
);

    localparam int                GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    // Lengths above the pattern width are sent as a full-width pattern.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN_L) ? MAX_LEN_L : l;
    endfunction

    // Bit select with a counter-width index; indices past the pattern read 0.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] p,
                                      input logic [LEN_W-1:0]   idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == LEN_W'(i)) b = p[i];
        end
        return b;
    endfunction

    state_t             state_q, state_nxt;
    logic [LEN_W-1:0]   bit_q, bit_nxt;     // index of the bit on the line
    logic [CNT_W-1:0]   pass_q, pass_nxt;   // passes still to go after this one
    logic [GAP_W-1:0]   gap_q, gap_nxt;     // idle cycles left in the gap
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               accept;
    logic               out_d, vld_d, done_d, rdy_d;

    // State, counters and registered outputs; data latches are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            pass_q    <= '0;
            gap_q     <= '0;
            ready     <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            bit_q     <= bit_nxt;
            pass_q    <= pass_nxt;
            gap_q     <= gap_nxt;
            ready     <= rdy_d;
            out       <= out_d;
            out_valid <= vld_d;
            done      <= done_d;
        end
    end

    // Job parameters are captured once at acceptance and held for the job.
    always_ff @(posedge clk) begin
        if (accept) begin
            pat_q <= pattern;
            len_q <= clamp_len(len);
        end
    end

    // Next-state and counter sequencing; abort overrides everything.
    always_comb begin
        state_nxt = state_q;
        bit_nxt   = bit_q;
        pass_nxt  = pass_q;
        gap_nxt   = gap_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort && (len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = ST_SEND;
                    bit_nxt   = clamp_len(len) - LEN_W'(1);
                    pass_nxt  = repeat_cnt;
                end
            end
            ST_SEND: begin
                if (bit_q != '0) begin
                    bit_nxt = bit_q - LEN_W'(1);
                end else if (pass_q != '0) begin
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_LAST;
                    end else begin
                        bit_nxt  = len_q - LEN_W'(1);
                        pass_nxt = pass_q - CNT_W'(1);
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_nxt = ST_SEND;
                    bit_nxt   = len_q - LEN_W'(1);
                    pass_nxt  = pass_q - CNT_W'(1);
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // Output decode from the upcoming state; pattern comes straight from the
    // port on the accepting cycle since the latch updates on the same edge.
    always_comb begin
        out_d  = 1'b0;
        vld_d  = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
        case (state_nxt)
            ST_SEND: begin
                vld_d  = 1'b1;
                out_d  = pick_bit(accept ? pattern : pat_q, bit_nxt);
                done_d = (bit_nxt == '0) && (pass_nxt == '0);
            end
            ST_IDLE: rdy_d = 1'b1;
            default: ;
        endcase
    end

endmodule : sequence_generator
